cache_fill_mux: RTL and testbench
=================================

Name: cache_fill_mux

Overview:
- Parametrised, handshaked successor of the cache data-in selector.
- Selects one of NUM_SRC word sources (AHB, SRAM1/2, SD1..3 in the current build) on a start command.
- Streams a BURST_LEN-word cache-line fill through a one-entry output register to the cache write port, using valid/ready flow control, and pulses done at the end.
- Sits between the source datapaths and the cache data input.

Parameters:
- DATA_W, 32, word width.
- NUM_SRC, 6, number of sources; select codes 1..NUM_SRC, code 0 means none.
- BURST_LEN, 4, words per fill (>=1).
- SEL_W, $clog2(NUM_SRC+1), select-code width (derived localparam).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle fill request
- sel_in  in  SEL_W  source code sampled with start
- src_data  in  NUM_SRC*DATA_W  packed source words; source k (1-based) occupies bits [k*DATA_W-1 -: DATA_W]
- src_valid  in  NUM_SRC  per-source word valid
- src_ready  out  NUM_SRC  per-source word accepted
- out_data  out  DATA_W  word to cache
- out_valid  out  1  out_data valid
- out_ready  in  1  cache accepts out_data
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when the last word has left the output register
- sel_err  out  1  one-cycle pulse on start with an illegal code

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low on n_rst. Reset values: state IDLE; sel_q 0; word count 0; out_valid 0; out_data 0; busy 0; done 0; sel_err 0; src_ready all 0.
- States:
  - IDLE: start=1 and 1<=sel_in<=NUM_SRC latches sel_q, clears count, and moves to XFER. start=1 with sel_in=0 or sel_in>NUM_SRC pulses sel_err next cycle and stays in IDLE.
  - XFER: busy=1.
    - take = (!out_valid || out_ready).
    - src_ready[sel_q-1] = take (combinational); all other src_ready bits are 0.
    - On src_valid[sel_q-1] && take, the word loads into out_data with out_valid=1 the next cycle (1-cycle latency), and count increments.
    - When the accepted word is number BURST_LEN-1 (count==BURST_LEN-1), go to DRAIN.
  - DRAIN: busy=1, all src_ready=0. When out_valid==0, or on out_valid && out_ready: pulse done and go to IDLE.
- Output register: on out_valid && out_ready with no new load, out_valid clears and out_data returns to 0. out_data is always 0 when out_valid=0.
- Simultaneous drain and load in XFER gives full throughput of 1 word/cycle.
- start while busy is ignored; no error is raised.
- Non-selected sources are never acknowledged, whatever their valid.
- Source valid gaps stall the burst indefinitely; no timeout.
- BURST_LEN=1: the first accepted word moves the FSM straight to DRAIN.
- Count width is $clog2(BURST_LEN)+1. Count never wraps within a burst and resets on each start.
- Reset mid-burst: all state is cleared asynchronously; the partial line is discarded and done is not pulsed.

Optional Feature:
- Macro: CACHE_FILL_MUX_PARITY_EN.
- When defined: adds output port out_par (1 bit). It is the even parity (XOR reduction) of the word, registered alongside out_data, and is 0 when out_valid=0.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_mux_pkg: state enum (IDLE, XFER, DRAIN), source-code constants (SRC_NONE=0, SRC_AHB=1, SRC_SRAM1=2, SRC_SRAM2=3, SRC_SD1=4, SRC_SD2=5, SRC_SD3=6).
- One natural sub-module: cache_fill_outreg, the one-entry valid/ready output register (plus parity under the macro), instantiated once.

Test Plan:
- Reset → all outputs 0. Start sel_in=2, SRAM1 valid constantly with words 0xA0..0xA3, out_ready=1 → out_data A0,A1,A2,A3 on consecutive cycles starting 1 cycle after first accept; done pulses once; busy falls; src_ready[1] only.
- Backpressure: out_ready low for 3 cycles mid-burst → src_ready for the selected source drops, word held stable in out_data, no loss or duplication; total 4 words delivered in order.
- Illegal select: start with sel_in=0 and sel_in=7 → sel_err pulses 1 cycle each, busy stays 0, src_ready stays 0.
- Start while busy with sel_in=5 → ignored; burst continues from the original source; only one done.
- Assert n_rst mid-burst after 2 words → out_valid=0 and busy=0 immediately, no done. A new start with sel_in=4 fills 4 fresh words from SD1.
- PARITY_EN build: word 0x00000007 → out_par=1; word 0x00000003 → out_par=0; idle → 0.

Source files
------------

// File: rtl/cache_mux_pkg.sv
// Shared types and source-select codes for the cache fill multiplexer.
package cache_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned SRC_NONE  = 0;
  localparam int unsigned SRC_AHB   = 1;
  localparam int unsigned SRC_SRAM1 = 2;
  localparam int unsigned SRC_SRAM2 = 3;
  localparam int unsigned SRC_SD1   = 4;
  localparam int unsigned SRC_SD2   = 5;
  localparam int unsigned SRC_SD3   = 6;

endpackage

// File: rtl/cache_fill_outreg.sv
// One-entry valid/ready output register feeding the cache write port.
// CACHE_FILL_MUX_PARITY_EN adds a registered even-parity bit.
module cache_fill_outreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
`ifdef CACHE_FILL_MUX_PARITY_EN
  output logic              par_o,
`endif
  output logic              take_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
`ifdef CACHE_FILL_MUX_PARITY_EN
  logic              par_q;
`endif

  // Free slot, or the current word leaves this cycle.
  assign take_o  = !valid_q || ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

`ifdef CACHE_FILL_MUX_PARITY_EN
  assign par_o = par_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= 1'b0;
    end else if (load_i) begin
      par_q <= ^data_i;
    end else if (valid_q && ready_i) begin
      par_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/cache_fill_mux.sv
// Selects one of NUM_SRC word sources on start and streams a BURST_LEN-word line fill.
// Optional macro CACHE_FILL_MUX_PARITY_EN adds the out_par output.
//
// state | meaning
// IDLE  | waiting for start; checks the select code
// XFER  | accepting words from the source latched in sel_q
// DRAIN | last word held in the output register until the cache takes it
module cache_fill_mux
  import cache_mux_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NUM_SRC   = 6,
  parameter  int BURST_LEN = 4,
  localparam int SEL_W     = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef CACHE_FILL_MUX_PARITY_EN
  output logic                      out_par,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      sel_err
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              sel_err_q;

  logic              take;
  logic              accept;
  logic              sel_ok;
  logic [DATA_W-1:0] sel_word;

  assign sel_ok = (sel_in != '0) && (sel_in <= SEL_W'(NUM_SRC));

  always_comb begin
    src_ready = '0;
    sel_word  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k + 1)) begin
        src_ready[k] = (state_q == XFER) && take;
        sel_word     = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = |(src_valid & src_ready);

  cache_fill_outreg #(.DATA_W(DATA_W)) u_outreg (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (accept),
    .data_i  (sel_word),
    .ready_i (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
`ifdef CACHE_FILL_MUX_PARITY_EN
    .par_o   (out_par),
`endif
    .take_o  (take)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (sel_ok) begin
              sel_q   <= sel_in;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= XFER;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        XFER: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BURST_LEN - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Done only once the last word has actually left the output register.
          if (!out_valid || out_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            sel_q   <= SEL_W'(SRC_NONE);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_cache_fill_mux.sv
// Scoreboard bench for cache_fill_mux: stimulus pushes expected words, a monitor pops on handshake.
module tb_cache_fill_mux;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;

  logic                      clk = 1'b0;
  logic                      n_rst = 1'b0;
  logic                      start = 1'b0;
  logic [SEL_W-1:0]          sel_in = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic                      busy;
  logic                      done;
  logic                      sel_err;
`ifdef CACHE_FILL_MUX_PARITY_EN
  logic                      out_par;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_out     = 0;
  int done_cnt  = 0;
  logic [31:0] exp_q[$];
  int idx[NUM_SRC];
  logic [NUM_SRC-1:0] acc;

  cache_fill_mux dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .sel_in    (sel_in),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CACHE_FILL_MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_words(input logic [31:0] first);
    for (int i = 0; i < 4; i++) exp_q.push_back(first + 32'(i));
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!done && cyc < maxc);
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Source k (1-based) presents 0x80 + 16*k + words_taken; all sources always valid.
  initial begin
    for (int k = 0; k < NUM_SRC; k++) idx[k] = 0;
    acc       = '0;
    src_valid = '1;
    src_data  = '0;
    forever begin
      for (int k = 0; k < NUM_SRC; k++) if (acc[k]) idx[k]++;
      for (int k = 0; k < NUM_SRC; k++)
        src_data[k*DATA_W +: DATA_W] = 32'h80 + 32'((k + 1) * 16) + 32'(idx[k]);
      #4;
      acc = src_valid & src_ready;
      @(negedge clk);
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk); #4;
      if (!out_valid) check("idle_data_zero", out_data, 32'd0);
`ifdef CACHE_FILL_MUX_PARITY_EN
      if (!out_valid) check("idle_par_zero", 32'(out_par), 32'd0);
`endif
      if (n_rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_word: got %h expected none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("word", out_data, e);
`ifdef CACHE_FILL_MUX_PARITY_EN
          check("par", 32'(out_par), 32'(^e));
`endif
        end
        n_out++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int cyc;
    int d0;
    int n0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Burst 1: SRAM1 at full throughput
    @(negedge clk);
    push_words(32'hA0);
    d0 = done_cnt;
    start = 1'b1; sel_in = 3'd2;
    @(negedge clk);
    start = 1'b0; sel_in = 3'd0;
    #1;
    check("b1_busy", 32'(busy), 32'd1);
    check("b1_src_ready", 32'(src_ready), 32'b000010);
    wait_done(20, cyc);
    check("b1_latency", 32'(cyc), 32'd5);
    check("b1_busy_fall", 32'(busy), 32'd0);
    check("b1_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    check("b1_done_once", 32'(done), 32'd0);
    check("b1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Burst 2: backpressure for three cycles
    @(negedge clk);
    push_words(32'hA4);
    n0 = n_out;
    start = 1'b1; sel_in = 3'd2;
    @(negedge clk);
    start = 1'b0; sel_in = 3'd0;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("bp_hold_data", out_data, 32'hA5);
    check("bp_src_ready", 32'(src_ready), 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
      check("bp_hold_data", out_data, 32'hA5);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_src_ready", 32'(src_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_done(20, cyc);
    check("bp_busy_fall", 32'(busy), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("bp_word_count", 32'(n_out - n0), 32'd4);

    // Illegal select codes
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; sel_in = (t == 0) ? 3'd0 : 3'd7;
      @(negedge clk);
      start = 1'b0; sel_in = 3'd0;
      #1;
      check("ill_sel_err", 32'(sel_err), 32'd1);
      check("ill_busy", 32'(busy), 32'd0);
      check("ill_src_ready", 32'(src_ready), 32'd0);
      @(negedge clk); #1;
      check("ill_sel_err_pulse", 32'(sel_err), 32'd0);
    end

    // Start while busy is ignored
    @(negedge clk);
    push_words(32'hA8);
    d0 = done_cnt;
    start = 1'b1; sel_in = 3'd2;
    @(negedge clk);
    start = 1'b1; sel_in = 3'd5;
    @(negedge clk);
    start = 1'b0; sel_in = 3'd0;
    #1;
    check("busy_start_no_err", 32'(sel_err), 32'd0);
    check("busy_start_src", 32'(src_ready), 32'b000010);
    wait_done(20, cyc);
    repeat (3) @(negedge clk);
    #1;
    check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst after two words
    @(negedge clk);
    push_words(32'hAC);
    n0 = n_out;
    start = 1'b1; sel_in = 3'd2;
    @(negedge clk);
    start = 1'b0; sel_in = 3'd0;
    for (int i = 0; i < 20 && n_out < n0 + 2; i++) @(negedge clk);
    check("mid_two_words", 32'(n_out - n0), 32'd2);
    d0 = done_cnt;
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Fresh fill from SD1 after reset
    @(negedge clk);
    push_words(32'hC0);
    d0 = done_cnt;
    start = 1'b1; sel_in = 3'd4;
    @(negedge clk);
    start = 1'b0; sel_in = 3'd0;
    #1;
    check("sd1_src_ready", 32'(src_ready), 32'b001000);
    wait_done(20, cyc);
    check("sd1_latency", 32'(cyc), 32'd5);
    repeat (2) @(negedge clk);
    #1;
    check("sd1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
